// File: rtl/dmem_pkg.sv
// Shared types for the data-memory service stage.
//   DATA_W / ID_W / IDX_W : widths of data words, LSQ ids and word indices
//   dmem_req_t            : one queued request {idx, data, rw, id}
//   dmem_state_t          : service FSM state encoding
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int IDX_W  = 10;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              rw;    // 1 = store, 0 = load
        logic [ID_W-1:0]   id;
    } dmem_req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request FIFO for the data-memory service stage.
//   clk, rst       : clock, asynchronous active-high reset
//   push, wr_req   : enqueue wr_req at the tail (ignored while full)
//   pop            : dequeue the head (ignored while empty)
//   rd_req         : current head entry (valid while !empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries, 0..DEPTH
module dmem_req_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  dmem_req_t                wr_req,
    input  logic                     pop,
    output dmem_req_t                rd_req,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    dmem_req_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_req  = entries[rd_ptr];

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= wr_req;
        end
    end

endmodule

// File: rtl/dmem_service_unit.sv
// Data-memory service stage behind the load/store queue. Requests are queued
// in order and serviced one at a time against a word-addressed backing array
// with a fixed latency; each completion is reported with a one-cycle pulse.
//   clk, rst           : clock, asynchronous active-high reset
//   addr_in            : byte address, word index taken from bits [11:2]
//   data_in, rw_in     : store data, 1 = store / 0 = load
//   id_in, valid_in    : LSQ id, request strobe
//   data_out, id_out   : load data (or echoed store data) and id of completion
//   ready_out          : one-cycle completion pulse
//   stall_out          : FIFO full, request on valid_in is not taken
//
// Service FSM
//   state  | meaning
//   S_IDLE | nothing in service; pops the FIFO head when one is present
//   S_BUSY | request held in svc_req; cnt counts down, access at cnt == 0
module dmem_service_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       data_in,
    input  logic              rw_in,
    input  logic [3:0]        id_in,
    input  logic              valid_in,
    output logic [31:0]       data_out,
    output logic [3:0]        id_out,
    output logic              ready_out,
    output logic              stall_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    dmem_req_t        svc_req;
    dmem_req_t        new_req;
    dmem_req_t        head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;
    logic             push;
    logic             pop;
    logic             access;
    logic             mem_we;
    logic             unused_addr;

    logic [DATA_W-1:0] mem_array [MEM_WORDS];

    assign unused_addr = ^{addr_in[31:IDX_W+2], addr_in[1:0]};

    assign new_req.idx  = addr_in[IDX_W+1:2];
    assign new_req.data = data_in;
    assign new_req.rw   = rw_in;
    assign new_req.id   = id_in;

    // Stall comes only from the registered count, so a pop on the same edge
    // cannot make room for that edge's push.
    assign stall_out = (fifo_count == FULL_CNT);
    assign push      = valid_in && !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign access    = (state == S_BUSY) && (cnt == '0);
    assign mem_we    = access && svc_req.rw;

    dmem_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_req (new_req),
        .pop    (pop),
        .rd_req (head_req),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            svc_req   <= '0;
            data_out  <= '0;
            id_out    <= '0;
            ready_out <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        svc_req <= head_req;
                        cnt     <= LAT_INIT;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Loads read the array before this edge's write, which
                        // is harmless: a single request is either load or store.
                        data_out  <= svc_req.rw ? svc_req.data : mem_array[svc_req.idx];
                        id_out    <= svc_req.id;
                        ready_out <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Backing array is not reset; reset forces S_IDLE, so an in-flight store
    // never reaches this write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[svc_req.idx] <= svc_req.data;
        end
    end

endmodule

// File: tb/tb_dmem_service_unit.sv
module tb_dmem_service_unit;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // default build: DEPTH=4, LATENCY=2
    logic [31:0] addr, data;
    logic        rw, valid;
    logic [3:0]  id;
    logic [31:0] data_out;
    logic [3:0]  id_out;
    logic        ready_out, stall_out;

    // small build: DEPTH=2, LATENCY=1
    logic [31:0] s_addr, s_data;
    logic        s_rw, s_valid;
    logic [3:0]  s_id;
    logic [31:0] s_data_out;
    logic [3:0]  s_id_out;
    logic        s_ready_out, s_stall_out;

    exp_t        q[$];
    exp_t        sq[$];
    logic [31:0] mem_model  [1024];
    logic [31:0] smem_model [1024];
    int          resp_cyc   [16];
    int          s_resp_cyc [16];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    dmem_service_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .addr_in   (addr),
        .data_in   (data),
        .rw_in     (rw),
        .id_in     (id),
        .valid_in  (valid),
        .data_out  (data_out),
        .id_out    (id_out),
        .ready_out (ready_out),
        .stall_out (stall_out)
    );

    dmem_service_unit #(.DEPTH(2), .LATENCY(1)) u_small (
        .clk       (clk),
        .rst       (rst),
        .addr_in   (s_addr),
        .data_in   (s_data),
        .rw_in     (s_rw),
        .id_in     (s_id),
        .valid_in  (s_valid),
        .data_out  (s_data_out),
        .id_out    (s_id_out),
        .ready_out (s_ready_out),
        .stall_out (s_stall_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready_out) begin
            resp_cyc[id_out] = cyc;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL resp_unexpected id_out=%0d data_out=%h expected no response", id_out, data_out);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                assert (id_out === e.id && data_out === e.data) else begin
                    errors++;
                    $error("FAIL resp id=%0d data=%h expected id=%0d data=%h", id_out, data_out, e.id, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_ready_out) begin
            s_resp_cyc[s_id_out] = cyc;
            checks++;
            assert (sq.size() != 0) else begin
                errors++;
                $error("FAIL s_resp_unexpected id_out=%0d data_out=%h expected no response", s_id_out, s_data_out);
            end
            if (sq.size() != 0) begin
                e = sq.pop_front();
                checks++;
                assert (s_id_out === e.id && s_data_out === e.data) else begin
                    errors++;
                    $error("FAIL s_resp id=%0d data=%h expected id=%0d data=%h", s_id_out, s_data_out, e.id, e.data);
                end
            end
        end
    end

    // Drives one request, retrying while stalled; returns just after the
    // accepting edge with acc_cyc = edge count at acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic r,
                        input logic [3:0] i, output int acc_cyc);
        bit done = 0;
        int tries = 0;
        exp_t e;
        addr = a; data = d; rw = r; id = i; valid = 1'b1;
        while (!done && tries < 50) begin
            done = !stall_out;
            @(posedge clk); #1;
            tries++;
        end
        valid = 1'b0;
        acc_cyc = cyc;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL send_timeout id=%0d accepted=%0d expected 1", i, done);
        end
        if (done) begin
            e.id = i;
            if (r) begin
                mem_model[a[11:2]] = d;
                e.data = d;
            end else begin
                e.data = mem_model[a[11:2]];
            end
            q.push_back(e);
        end
    endtask

    task automatic send_s(input logic [31:0] a, input logic [31:0] d, input logic r,
                          input logic [3:0] i, output int acc_cyc);
        bit done = 0;
        int tries = 0;
        exp_t e;
        s_addr = a; s_data = d; s_rw = r; s_id = i; s_valid = 1'b1;
        while (!done && tries < 50) begin
            done = !s_stall_out;
            @(posedge clk); #1;
            tries++;
        end
        s_valid = 1'b0;
        acc_cyc = cyc;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL s_send_timeout id=%0d accepted=%0d expected 1", i, done);
        end
        if (done) begin
            e.id = i;
            if (r) begin
                smem_model[a[11:2]] = d;
                e.data = d;
            end else begin
                e.data = smem_model[a[11:2]];
            end
            sq.push_back(e);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout pending=%0d expected 0", q.size());
        end
    endtask

    task automatic drain_s();
        int k = 0;
        while (sq.size() != 0 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        assert (sq.size() == 0) else begin
            errors++;
            $error("FAIL s_drain_timeout pending=%0d expected 0", sq.size());
        end
    endtask

    initial begin
        int t0, t1;
        logic [31:0] old;
        rst = 1'b1;
        valid = 1'b0; addr = '0; data = '0; rw = 1'b0; id = '0;
        s_valid = 1'b0; s_addr = '0; s_data = '0; s_rw = 1'b0; s_id = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (data_out === 32'h0 && id_out === 4'h0 && ready_out === 1'b0 && stall_out === 1'b0) else begin
            errors++;
            $error("FAIL reset_out data=%h id=%0d ready=%b stall=%b expected all 0", data_out, id_out, ready_out, stall_out);
        end
        checks++;
        assert (s_data_out === 32'h0 && s_id_out === 4'h0 && s_ready_out === 1'b0 && s_stall_out === 1'b0) else begin
            errors++;
            $error("FAIL s_reset_out data=%h id=%0d ready=%b stall=%b expected all 0", s_data_out, s_id_out, s_ready_out, s_stall_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // store then load, first response three edges after the accept edge
        send(32'h010, 32'hDEADBEEF, 1'b1, 4'd3, t0);
        send(32'h010, 32'h0, 1'b0, 4'd4, t1);
        drain();
        checks++;
        assert (resp_cyc[3] - t0 === 3) else begin
            errors++;
            $error("FAIL first_latency got=%0d expected 3", resp_cyc[3] - t0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (ready_out === 1'b0 && data_out === 32'hDEADBEEF && id_out === 4'd4) else begin
            errors++;
            $error("FAIL hold ready=%b data=%h id=%0d expected 0 deadbeef 4", ready_out, data_out, id_out);
        end

        // back-to-back: the second pop shares an edge with the 5th push,
        // so the queue first fills on the 6th accept
        for (int i = 0; i < 8; i++) begin
            send(32'h100 + 32'(4 * (i % 4)), 32'hA000_0000 + 32'(i), (i < 4), 4'(i), t0);
            if (i == 4) begin
                checks++;
                assert (stall_out === 1'b0) else begin
                    errors++;
                    $error("FAIL stall_after_5 got=%b expected 0", stall_out);
                end
            end
            if (i == 5) begin
                checks++;
                assert (stall_out === 1'b1) else begin
                    errors++;
                    $error("FAIL stall_after_6 got=%b expected 1", stall_out);
                end
            end
        end
        drain();

        // aliasing: bits [1:0] and [31:12] ignored
        send(32'h0000_0004, 32'h1, 1'b1, 4'd8, t0);
        send(32'h0000_1004, 32'h2, 1'b1, 4'd9, t0);
        send(32'h0000_0007, 32'h0, 1'b0, 4'd10, t0);
        drain();

        // wrap-around with retries
        for (int i = 0; i < 12; i++) begin
            send(32'h200 + 32'(4 * (i / 2)), $urandom, (i % 2 == 0), 4'(i), t0);
        end
        drain();
        @(posedge clk); #1;
        checks++;
        assert (u_dut.u_fifo.count === 3'd0 && stall_out === 1'b0) else begin
            errors++;
            $error("FAIL wrap_end count=%0d stall=%b expected 0 0", u_dut.u_fifo.count, stall_out);
        end

        // reset while a store is in service
        send(32'h020, 32'h1111_1111, 1'b1, 4'd11, t0);
        drain();
        old = mem_model[8];
        send(32'h020, 32'h55, 1'b1, 4'd12, t0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        assert (data_out === 32'h0 && id_out === 4'h0 && ready_out === 1'b0 && stall_out === 1'b0) else begin
            errors++;
            $error("FAIL midreset_out data=%h id=%0d ready=%b stall=%b expected all 0", data_out, id_out, ready_out, stall_out);
        end
        q.delete();
        mem_model[8] = old;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(32'h020, 32'h0, 1'b0, 4'd13, t0);
        drain();

        // small build: DEPTH=2, LATENCY=1
        send_s(32'h040, 32'hCAFE_0001, 1'b1, 4'd1, t0);
        send_s(32'h040, 32'h0, 1'b0, 4'd2, t1);
        drain_s();
        checks++;
        assert (s_resp_cyc[2] - t0 === 4) else begin
            errors++;
            $error("FAIL s_load_latency got=%0d expected 4", s_resp_cyc[2] - t0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send_s(32'h080 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 4'(5 + i), t0);
            if (i == 1) begin
                checks++;
                assert (s_stall_out === 1'b0) else begin
                    errors++;
                    $error("FAIL s_stall_after_2 got=%b expected 0", s_stall_out);
                end
            end
            if (i == 2) begin
                checks++;
                assert (s_stall_out === 1'b1) else begin
                    errors++;
                    $error("FAIL s_stall_after_3 got=%b expected 1", s_stall_out);
                end
            end
        end
        drain_s();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
